// File: rtl/wb_vec_bridge_pkg.sv
// Shared constants for the Wishbone vector-stream bridge: address fields,
// register offsets, STATUS/CTRL bit positions and the per-channel error flags.
package wb_vec_bridge_pkg;

  // Address decode fields
  localparam int BASE_CMP_LSB = 16;
  localparam int CH_LSB       = 4;
  localparam int CH_MSB       = 7;
  localparam int REG_LSB      = 2;
  localparam int REG_MSB      = 3;

  // Register offsets within a channel
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_RX_EMPTY  = 3;
  localparam int ST_OVF       = 4;
  localparam int ST_UDF       = 5;
  localparam int ST_SEL_ERR   = 6;
  localparam int ST_TXCNT_LSB = 8;
  localparam int ST_RXCNT_LSB = 16;

  // CTRL bit positions
  localparam int CTRL_CLR        = 0;
  localparam int CTRL_FLUSH      = 1;
  localparam int CTRL_RX_IRQ_EN  = 2;
  localparam int CTRL_ERR_IRQ_EN = 3;

  localparam logic [3:0] SEL_WORD = 4'hF;

  // Sticky per-channel error flags
  typedef struct packed {
    logic sel_err;
    logic udf;
    logic ovf;
  } ch_err_t;

  // CTRL readback: only the two enables are visible
  function automatic logic [31:0] ctrl_rd(input logic rx_en, input logic err_en);
    logic [31:0] v;
    v = '0;
    v[CTRL_RX_IRQ_EN]  = rx_en;
    v[CTRL_ERR_IRQ_EN] = err_en;
    return v;
  endfunction

endpackage

// File: rtl/vec_sync_fifo.sv
// Synchronous FIFO, no fall-through. Push is taken when not full or when a
// real pop happens on the same edge. Flush empties it and overrides push/pop.
module vec_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/wb_vec_bridge.sv
// Wishbone-classic slave fronting NUM_CH vector stream channels, each with a
// TX FIFO (bus -> coprocessor), RX FIFO (coprocessor -> bus), sticky error
// flags and interrupt enables.
module wb_vec_bridge
  import wb_vec_bridge_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NUM_CH-1:0]     tx_valid,
  input  logic [NUM_CH-1:0]     tx_ready,
  output logic [32*NUM_CH-1:0]  tx_data,
  input  logic [NUM_CH-1:0]     rx_valid,
  output logic [NUM_CH-1:0]     rx_ready,
  input  logic [32*NUM_CH-1:0]  rx_data,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        ack_q, irq_q;
  logic [31:0] dat_q, rd_d;
  logic        hit, fire, ch_ok, sel_word;
  logic [3:0]  ch_idx;
  logic [1:0]  reg_idx;

  logic [NUM_CH-1:0][31:0] status_w, ctrl_w, rxhd_w;
  logic [NUM_CH-1:0]       irq_c;

  assign ch_idx   = wbs_adr_i[CH_MSB:CH_LSB];
  assign reg_idx  = wbs_adr_i[REG_MSB:REG_LSB];
  assign hit      = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[31:BASE_CMP_LSB] == BASE_ADDR[31:BASE_CMP_LSB]);
  // A transfer commits only on the cycle ack is about to rise
  assign fire     = hit & ~ack_q;
  assign ch_ok    = ({28'b0, ch_idx} < 32'(NUM_CH));
  assign sel_word = (wbs_sel_i == SEL_WORD);

  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[BASE_CMP_LSB-1:CH_MSB+1], wbs_adr_i[REG_LSB-1:0]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          sel_c, wr_data, rd_data, wr_ctrl, flush, clr;
    logic          tx_pop, tx_push, tx_full, tx_empty;
    logic          rx_pop, rx_push, rx_full, rx_empty;
    logic [31:0]   tx_head, rx_head;
    logic [CW-1:0] tx_cnt, rx_cnt;
    ch_err_t       err_q, err_d;
    logic          rx_en_q, err_en_q;
    logic [31:0]   st;

    assign sel_c   = fire & ch_ok & (ch_idx == 4'(c));
    assign wr_data = sel_c &  wbs_we_i & (reg_idx == REG_DATA);
    assign rd_data = sel_c & ~wbs_we_i & (reg_idx == REG_DATA);
    assign wr_ctrl = sel_c &  wbs_we_i & (reg_idx == REG_CTRL);
    assign flush   = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
    assign clr     = wr_ctrl & wbs_dat_i[CTRL_CLR];

    assign tx_pop  = ~tx_empty & tx_ready[c];
    assign tx_push = wr_data & sel_word;
    assign rx_pop  = rd_data & ~rx_empty;
    assign rx_push = rx_valid[c] & ~rx_full;

    vec_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk(clk), .rst_n(reset_n), .push_i(tx_push), .pop_i(tx_pop),
      .flush_i(flush), .din_i(wbs_dat_i), .dout_o(tx_head),
      .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
    );

    vec_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk(clk), .rst_n(reset_n), .push_i(rx_push), .pop_i(rx_pop),
      .flush_i(flush), .din_i(rx_data[32*c +: 32]), .dout_o(rx_head),
      .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
    );

    assign tx_valid[c]          = ~tx_empty;
    assign tx_data[32*c +: 32]  = tx_head;
    assign rx_ready[c]          = ~rx_full;

    // Sticky error flags: clear first, then sets so a set wins
    always_comb begin
      err_d = err_q;
      if (clr) err_d = '0;
      if (wr_data & ~sel_word)                       err_d.sel_err = 1'b1;
      if (tx_push & tx_full & ~tx_pop)               err_d.ovf     = 1'b1;
      if (rd_data & rx_empty)                        err_d.udf     = 1'b1;
    end

    // Error flags and interrupt enables
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        err_q    <= '0;
        rx_en_q  <= 1'b0;
        err_en_q <= 1'b0;
      end else begin
        err_q <= err_d;
        if (wr_ctrl) begin
          rx_en_q  <= wbs_dat_i[CTRL_RX_IRQ_EN];
          err_en_q <= wbs_dat_i[CTRL_ERR_IRQ_EN];
        end
      end
    end

    // STATUS word assembly
    always_comb begin
      st = '0;
      st[ST_TX_FULL]            = tx_full;
      st[ST_TX_EMPTY]           = tx_empty;
      st[ST_RX_FULL]            = rx_full;
      st[ST_RX_EMPTY]           = rx_empty;
      st[ST_OVF]                = err_q.ovf;
      st[ST_UDF]                = err_q.udf;
      st[ST_SEL_ERR]            = err_q.sel_err;
      st[ST_TXCNT_LSB +: 8]     = 8'(tx_cnt);
      st[ST_RXCNT_LSB +: 8]     = 8'(rx_cnt);
    end

    assign status_w[c] = st;
    assign ctrl_w[c]   = ctrl_rd(rx_en_q, err_en_q);
    assign rxhd_w[c]   = rx_empty ? 32'h0 : rx_head;
    assign irq_c[c]    = (rx_en_q & ~rx_empty) | (err_en_q & (|err_q));
  end

  // Read data mux; writes, misses and absent channels read as zero
  always_comb begin
    rd_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!wbs_we_i && ch_ok && ch_idx == 4'(c)) begin
        case (reg_idx)
          REG_DATA:   rd_d = rxhd_w[c];
          REG_STATUS: rd_d = status_w[c];
          REG_CTRL:   rd_d = ctrl_w[c];
          REG_RSVD:   rd_d = '0;
          default:    rd_d = '0;
        endcase
      end
    end
  end

  // Bus response and interrupt registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= fire;
      dat_q <= fire ? rd_d : 32'h0;
      irq_q <= |irq_c;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_wb_vec_bridge.sv
// Randomized + directed bench for wb_vec_bridge against a queue-based model.
module tb_wb_vec_bridge;

  localparam int NCH = 2;
  localparam int D   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NCH-1:0]    tx_valid, tx_ready, rx_valid, rx_ready;
  logic [32*NCH-1:0] tx_data, rx_data;
  logic              irq;

  always #5 clk = ~clk;

  wb_vec_bridge #(.NUM_CH(NCH), .FIFO_DEPTH(D), .BASE_ADDR(32'h3000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] txq [NCH][$];
  logic [31:0] rxq [NCH][$];
  bit ovf_m [NCH], udf_m [NCH], sel_m [NCH], rxen_m [NCH], erren_m [NCH];
  bit m_ack, m_irq;
  logic [31:0] m_dat;

  // stream stimulus applied on each step
  logic [NCH-1:0]    tx_rdy_v;
  logic [NCH-1:0]    rx_vld_v;
  logic [32*NCH-1:0] rx_dat_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status(input int c);
    logic [31:0] s;
    s = '0;
    s[0] = (txq[c].size() == D);
    s[1] = (txq[c].size() == 0);
    s[2] = (rxq[c].size() == D);
    s[3] = (rxq[c].size() == 0);
    s[4] = ovf_m[c];
    s[5] = udf_m[c];
    s[6] = sel_m[c];
    s[15:8]  = 8'(txq[c].size());
    s[23:16] = 8'(rxq[c].size());
    return s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      txq[c].delete(); rxq[c].delete();
      ovf_m[c] = 0; udf_m[c] = 0; sel_m[c] = 0; rxen_m[c] = 0; erren_m[c] = 0;
    end
    m_ack = 0; m_irq = 0; m_dat = 0;
  endtask

  // One clock: drive at negedge, check stream outputs, predict, check after posedge
  task automatic step(input bit stb, input bit we, input logic [3:0] sel,
                      input logic [31:0] adr, input logic [31:0] wd);
    bit hit, fire, dopush, dorxpop, irq_n;
    bit txpop [NCH];
    bit rxpush [NCH];
    bit flush [NCH];
    int ch, rg;
    logic [31:0] rd;
    @(negedge clk);
    wbs_cyc_i = stb; wbs_stb_i = stb; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = wd;
    tx_ready = tx_rdy_v; rx_valid = rx_vld_v; rx_data = rx_dat_v;
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("tx_valid%0d", c), 32'(tx_valid[c]), 32'(txq[c].size() > 0));
      if (txq[c].size() > 0) chk($sformatf("tx_data%0d", c), tx_data[32*c +: 32], txq[c][0]);
      chk($sformatf("rx_ready%0d", c), 32'(rx_ready[c]), 32'(rxq[c].size() < D));
    end
    hit  = stb && (adr[31:16] == 16'h3000);
    fire = hit && !m_ack;
    ch = int'(adr[7:4]); rg = int'(adr[3:2]);
    rd = 0; dopush = 0; dorxpop = 0; irq_n = 0;
    for (int c = 0; c < NCH; c++) begin
      irq_n |= (rxen_m[c] && rxq[c].size() > 0) || (erren_m[c] && (ovf_m[c] || udf_m[c] || sel_m[c]));
      txpop[c]  = (txq[c].size() > 0) && tx_rdy_v[c];
      rxpush[c] = rx_vld_v[c] && (rxq[c].size() < D);
      flush[c]  = 0;
    end
    if (fire && ch < NCH) begin
      case (rg)
        0: if (we) begin
             if (sel != 4'hF) sel_m[ch] = 1;
             else if (txq[ch].size() < D || txpop[ch]) dopush = 1;
             else ovf_m[ch] = 1;
           end else begin
             if (rxq[ch].size() > 0) begin rd = rxq[ch][0]; dorxpop = 1; end
             else udf_m[ch] = 1;
           end
        1: if (!we) rd = m_status(ch);
        2: if (we) begin
             if (wd[0]) begin ovf_m[ch] = 0; udf_m[ch] = 0; sel_m[ch] = 0; end
             flush[ch] = wd[1]; rxen_m[ch] = wd[2]; erren_m[ch] = wd[3];
           end else rd = {28'b0, erren_m[ch], rxen_m[ch], 2'b0};
        default: ;
      endcase
    end
    for (int c = 0; c < NCH; c++) begin
      if (flush[c]) begin
        txq[c].delete(); rxq[c].delete();
      end else begin
        if (txpop[c]) void'(txq[c].pop_front());
        if (c == ch && dopush) txq[c].push_back(wd);
        if (c == ch && dorxpop) void'(rxq[c].pop_front());
        if (rxpush[c]) rxq[c].push_back(rx_dat_v[32*c +: 32]);
      end
    end
    m_ack = fire; m_dat = fire ? rd : 32'h0; m_irq = irq_n;
    @(posedge clk); #1;
    chk("ack", 32'(wbs_ack_o), 32'(m_ack));
    chk("dat", wbs_dat_o, m_dat);
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'hF, 32'h0, 32'h0);
  endtask

  // single transfer; returns with ack visible (posedge + 1)
  task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
    step(1, we, sel, adr, wd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr, wd;
    logic [3:0]  sel;
    bit          stb, we;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    tx_rdy_v = 0; rx_vld_v = 0; rx_dat_v = 0;
    model_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wbs_ack_o), 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_txv", 32'(tx_valid), 0);
    chk("rst_rxr", 32'(rx_ready), 32'(2'b11));
    @(negedge clk); reset_n = 1;

    // STATUS after reset
    bus(0, 32'h3000_0004, 0, 4'hF);
    chk("st_reset", wbs_dat_o, 32'h0000_000A);
    idle(1);

    // fill TX of ch0 past depth with the stream stalled
    for (int i = 1; i <= 5; i++) begin
      bus(1, 32'h3000_0000, 32'(i * 'h11), 4'hF); idle(1);
    end
    bus(0, 32'h3000_0004, 0, 4'hF);
    chk("st_ovf", wbs_dat_o, 32'h0000_0419);
    idle(1);
    tx_rdy_v = 2'b01;
    idle(6);
    tx_rdy_v = 0;
    bus(1, 32'h3000_0008, 32'h1, 4'hF); idle(1);

    // RX on ch1 with rx irq enabled
    bus(1, 32'h3000_0018, 32'h4, 4'hF); idle(1);
    rx_vld_v = 2'b10; rx_dat_v = {32'hDEAD_BEEF, 32'h0};
    idle(1);
    rx_vld_v = 0;
    idle(2);
    chk("irq_rx", 32'(irq), 1);
    bus(0, 32'h3000_0010, 0, 4'hF);
    chk("rx_data", wbs_dat_o, 32'hDEAD_BEEF);
    idle(3);
    chk("irq_clr", 32'(irq), 0);
    bus(1, 32'h3000_0018, 32'h0, 4'hF); idle(1);

    // underflow on ch0, then clear
    bus(0, 32'h3000_0000, 0, 4'hF);
    chk("udf_rd", wbs_dat_o, 0); idle(1);
    bus(1, 32'h3000_0008, 32'h1, 4'hF); idle(1);
    bus(0, 32'h3000_0004, 0, 4'hF);
    chk("udf_clr", 32'(wbs_dat_o[5]), 0); idle(1);

    // partial select write, absent channel
    bus(1, 32'h3000_0000, 32'h77, 4'h3); idle(1);
    bus(0, 32'h3000_0004, 0, 4'hF);
    chk("sel_err", 32'(wbs_dat_o[6]), 1); idle(1);
    bus(0, 32'h3000_0054, 0, 4'hF);
    chk("ch5_ack", 32'(wbs_ack_o), 1);
    chk("ch5_dat", wbs_dat_o, 0); idle(1);
    bus(1, 32'h3000_0050, 32'h99, 4'hF); idle(1);
    // miss never acks, held strobe on a hit acks every 2nd cycle
    step(1, 0, 4'hF, 32'h3001_0004, 0);
    step(1, 0, 4'hF, 32'h3001_0004, 0);
    step(1, 0, 4'hF, 32'h3000_0004, 0);
    step(1, 0, 4'hF, 32'h3000_0004, 0);
    step(1, 0, 4'hF, 32'h3000_0004, 0);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tx_rdy_v = NCH'($urandom);
      rx_vld_v = NCH'($urandom);
      rx_dat_v = {$urandom, $urandom};
      stb = ($urandom_range(0, 9) < 7);
      we  = 1'($urandom);
      adr = 32'h3000_0000 | (32'($urandom_range(0, 2)) << 4) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 15) == 0) adr[7:4] = 4'($urandom_range(2, 15));
      if ($urandom_range(0, 15) == 0) adr[31:16] = 16'h3005;
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      wd  = $urandom;
      if (adr[3:2] == 2'd2) wd[1] = ($urandom_range(0, 7) == 0);
      step(stb, we, sel, adr, wd);
    end
    tx_rdy_v = 0; rx_vld_v = 0;
    idle(2);

    // reset while TX holds two entries and ack is high
    bus(1, 32'h3000_0008, 32'h3, 4'hF); idle(1);
    bus(1, 32'h3000_0000, 32'hA1, 4'hF); idle(1);
    bus(1, 32'h3000_0000, 32'hA2, 4'hF); idle(1);
    bus(0, 32'h3000_0004, 0, 4'hF);
    chk("pre_rst_ack", 32'(wbs_ack_o), 1);
    reset_n = 0;
    #1;
    chk("mid_rst_ack", 32'(wbs_ack_o), 0);
    chk("mid_rst_txv", 32'(tx_valid), 0);
    chk("mid_rst_rxr", 32'(rx_ready), 32'(2'b11));
    model_reset();
    @(negedge clk); reset_n = 1;
    idle(1);
    bus(0, 32'h3000_0004, 0, 4'hF);
    chk("post_rst_st", wbs_dat_o, 32'h0000_000A);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
